// File: rtl/aes_enc_arbiter_pkg.sv
// Shared constants for the AES encryption arbiter: requester count, widths,
// watchdog default and FSM state encoding.
package aes_enc_arbiter_pkg;

   localparam int N_REQ_DEF  = 4;
   localparam int IDW        = 2;
   localparam int WD_MAX_DEF = 24;
   localparam int BLK_W      = 128;

   typedef logic [IDW-1:0] id_t;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_KEY_LD = 3'd1;
   localparam logic [2:0] S_KEY_WT = 3'd2;
   localparam logic [2:0] S_DAT_LD = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/aes_enc_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: first requesting index found
// searching upward from last_grant+1 with wrap.
module aes_rr_pick
   import aes_enc_arbiter_pkg::*;
(
   input  logic [N_REQ_DEF-1:0] req,
   input  logic [IDW-1:0]       last_grant,
   output logic [IDW-1:0]       grant,
   output logic                 any
);

   logic [IDW-1:0]       cand [N_REQ_DEF];
   logic [N_REQ_DEF-1:0] hit;

   // cand[gi] is the requester at distance gi+1 from the previous winner
   for (genvar gi = 0; gi < N_REQ_DEF; gi++) begin : g_cand
      assign cand[gi] = last_grant + IDW'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
   end

   always_comb begin
      grant = last_grant;
      any   = 1'b0;
      for (int k = N_REQ_DEF - 1; k >= 0; k--) begin
         if (hit[k]) begin
            grant = cand[k];
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Round-robin front end sharing one external AES core among four requesters,
// with key caching and a RUN-state watchdog that resets the core on a hang.
module aes_enc_arbiter
   import aes_enc_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int WD_MAX = WD_MAX_DEF
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*BLK_W-1:0]   key_i,
   input  logic [N_REQ*BLK_W-1:0]   din_i,
   output logic [N_REQ-1:0]         ack,
   output logic [BLK_W-1:0]         dout,
   output logic                     dout_vld,
   output logic [IDW-1:0]           dout_id,
   output logic                     err,
   output logic                     busy,
   output logic [BLK_W-1:0]         aes_kin,
   output logic [BLK_W-1:0]         aes_din,
   output logic                     aes_krdy,
   output logic                     aes_drdy,
   output logic                     aes_en,
   output logic                     aes_rstn,
   input  logic                     aes_bsy,
   input  logic                     aes_kvld,
   input  logic                     aes_dvld,
   input  logic [BLK_W-1:0]         aes_dout
);

   localparam int WD_W = $clog2(WD_MAX + 1);

   logic [2:0]        state_reg, state_next;
   logic [IDW-1:0]    grant_reg, last_grant_reg, dout_id_reg;
   logic              key_valid_reg, err_reg;
   logic [BLK_W-1:0]  key_cache_reg, dout_reg;
   logic [WD_W-1:0]   wd_reg;

   logic [BLK_W-1:0]  key_arr [N_REQ];
   logic [BLK_W-1:0]  din_arr [N_REQ];
   logic [IDW-1:0]    pick_grant;
   logic              pick_any, key_hit, run_done, wd_expire;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign key_arr[gi] = key_i[gi*BLK_W +: BLK_W];
      assign din_arr[gi] = din_i[gi*BLK_W +: BLK_W];
   end

   aes_rr_pick u_pick (
      .req        (req),
      .last_grant (last_grant_reg),
      .grant      (pick_grant),
      .any        (pick_any)
   );

   assign key_hit   = key_valid_reg && (key_cache_reg == key_arr[pick_grant]);
   assign run_done  = aes_dvld && !aes_bsy;
   // a result arriving on the last allowed cycle still wins over the watchdog
   assign wd_expire = (wd_reg == WD_W'(WD_MAX - 1)) && !run_done;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (pick_any) state_next = key_hit ? S_DAT_LD : S_KEY_LD;
         S_KEY_LD: state_next = S_KEY_WT;
         S_KEY_WT: if (aes_kvld) state_next = S_DAT_LD;
         S_DAT_LD: state_next = S_RUN;
         S_RUN: begin
            if (run_done)       state_next = S_DONE;
            else if (wd_expire) state_next = S_IDLE;
         end
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= S_IDLE;
         grant_reg      <= '0;
         last_grant_reg <= IDW'(N_REQ - 1);
         key_valid_reg  <= 1'b0;
         key_cache_reg  <= '0;
         wd_reg         <= '0;
         dout_reg       <= '0;
         dout_id_reg    <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= 1'b0;
         case (state_reg)
            S_IDLE:   if (pick_any) grant_reg <= pick_grant;
            S_KEY_LD: key_cache_reg <= key_arr[grant_reg];
            S_KEY_WT: if (aes_kvld) key_valid_reg <= 1'b1;
            S_DAT_LD: wd_reg <= '0;
            S_RUN: begin
               if (run_done) begin
                  dout_reg    <= aes_dout;
                  dout_id_reg <= grant_reg;
               end else if (wd_expire) begin
                  // core is reset by the err pulse, so its expanded key is lost
                  err_reg        <= 1'b1;
                  key_valid_reg  <= 1'b0;
                  last_grant_reg <= grant_reg;
               end else begin
                  wd_reg <= wd_reg + WD_W'(1);
               end
            end
            S_DONE:   last_grant_reg <= grant_reg;
            default: ;
         endcase
      end
   end

   assign busy     = (state_reg != S_IDLE);
   assign aes_krdy = (state_reg == S_KEY_LD);
   assign aes_drdy = (state_reg == S_DAT_LD);
   assign aes_kin  = aes_krdy ? key_arr[grant_reg] : '0;
   assign aes_din  = aes_drdy ? din_arr[grant_reg] : '0;
   assign ack      = aes_drdy ? (N_REQ'(1) << grant_reg) : '0;
   assign dout_vld = (state_reg == S_DONE);
   assign dout     = dout_reg;
   assign dout_id  = dout_id_reg;
   assign err      = err_reg;
   assign aes_en   = ~RST;
   assign aes_rstn = ~RST & ~err_reg;

endmodule
